// File: rtl/seg7_pkg.sv
// seg7_pkg: shared 7-segment pattern table (active-low form) for the scan decoder.
package seg7_pkg;
    localparam logic [6:0] SEG7_BLANK = 7'h7F;
    localparam logic [6:0] SEG7_PAT [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };
endpackage

// File: rtl/seg7_to_hex.sv
// seg7_to_hex: active-low segment pattern -> {hit, nibble}.
// SEG7_SCAN_DEC_ONLY_EN restricts accepted patterns to the decimal digits 0..9.
module seg7_to_hex
    import seg7_pkg::*;
(
    input  logic [6:0] pat_i,
    output logic       hit_o,
    output logic [3:0] nib_o
);
`ifdef SEG7_SCAN_DEC_ONLY_EN
    localparam int N = 10;
`else
    localparam int N = 16;
`endif
    always_comb begin
        hit_o = 1'b0;
        nib_o = 4'd0;
        for (int k = 0; k < N; k++)
            if (pat_i == SEG7_PAT[k]) begin
                hit_o = 1'b1;
                nib_o = 4'(k);
            end
    end
endmodule

// File: rtl/seg7_scan_decoder.sv
// seg7_scan_decoder: snoops a scanned seg/anode bus, captures settled digits, publishes whole frames.
// SEG7_SCAN_DEC_ONLY_EN (via seg7_to_hex) makes hex patterns A..F decode as illegal.
module seg7_scan_decoder
    import seg7_pkg::*;
#(
    parameter int DIGITS        = 4,
    parameter int INVERT        = 1,
    parameter int STABLE_CYCLES = 4
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic [6:0]            seg,
    input  logic [DIGITS-1:0]     an,
    output logic [4*DIGITS-1:0]   hex_out,
    output logic [DIGITS-1:0]     digit_ok,
    output logic                  frame_vld,
    output logic                  err
);
    localparam logic [7:0] CMAX = 8'(STABLE_CYCLES);
    localparam logic [7:0] CSTRB = 8'(STABLE_CYCLES - 2);

    logic [6:0]          seg_q, seg_p_q;
    logic [DIGITS-1:0]   an_q, an_p_q;
    logic [7:0]          cnt_q, cnt_d;
    logic [4*DIGITS-1:0] sh_q, sh_d, hex_q, hex_d;
    logic [DIGITS-1:0]   sh_ok_q, sh_ok_d, ok_q, ok_d, seen_q, seen_d;
    logic                fv_q, err_q, err_d;
    logic                diff, strobe, commit, hit;
    logic [6:0]          pat;
    logic [3:0]          nib;

    assign pat = (INVERT != 0) ? seg_q : ~seg_q;

    seg7_to_hex u_dec (.pat_i(pat), .hit_o(hit), .nib_o(nib));

    // Strobe on the edge where the counter reaches STABLE_CYCLES-1; saturation prevents re-capture.
    always_comb begin
        diff    = {an_q, seg_q} != {an_p_q, seg_p_q};
        cnt_d   = diff ? 8'd0 : (cnt_q == CMAX ? cnt_q : cnt_q + 8'd1);
        strobe  = !diff && cnt_q == CSTRB;
        commit  = &seen_q;
        hex_d   = commit ? sh_q : hex_q;
        ok_d    = commit ? sh_ok_q : ok_q;
        seen_d  = commit ? '0 : seen_q;
        sh_d    = sh_q;
        sh_ok_d = sh_ok_q;
        err_d   = 1'b0;
        if (strobe && an_q != '0) begin
            if (!$onehot(an_q))
                err_d = 1'b1;
            else
                for (int i = 0; i < DIGITS; i++)
                    if (an_q[i]) begin
                        sh_d[4*i +: 4] = hit ? nib : 4'd0;
                        sh_ok_d[i]     = hit;
                        seen_d[i]      = 1'b1;
                        err_d          = !hit;
                    end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_q   <= '0;
            seg_p_q <= '0;
            an_q    <= '0;
            an_p_q  <= '0;
            cnt_q   <= '0;
            sh_q    <= '0;
            sh_ok_q <= '0;
            seen_q  <= '0;
            hex_q   <= '0;
            ok_q    <= '0;
            fv_q    <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            seg_q   <= seg;
            seg_p_q <= seg_q;
            an_q    <= an;
            an_p_q  <= an_q;
            cnt_q   <= cnt_d;
            sh_q    <= sh_d;
            sh_ok_q <= sh_ok_d;
            seen_q  <= seen_d;
            hex_q   <= hex_d;
            ok_q    <= ok_d;
            fv_q    <= commit;
            err_q   <= err_d;
        end
    end

    assign hex_out   = hex_q;
    assign digit_ok  = ok_q;
    assign frame_vld = fv_q;
    assign err       = err_q;
endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb_seg7_scan_decoder: directed and random scans against a run-length based frame model.
module tb_seg7_scan_decoder;
    localparam int S = 4;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [6:0]  seg = '0;
    logic [3:0]  an = '0;
    logic [15:0] hex_out;
    logic [3:0]  digit_ok;
    logic        frame_vld, err;

    int checks = 0, errors = 0, fv_cnt = 0, err_cnt = 0;

    logic [6:0] tbl [16] = '{
        7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
        7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
        7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
        7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
    };

    logic [10:0] m_prev;
    int          m_run;
    logic [15:0] m_sh, m_hex;
    logic [3:0]  m_shok, m_ok, m_seen;
    logic        m_fv, m_err;

    seg7_scan_decoder #(.DIGITS(4), .INVERT(1), .STABLE_CYCLES(S)) dut (
        .clk(clk), .rst_n(rst_n), .seg(seg), .an(an),
        .hex_out(hex_out), .digit_ok(digit_ok), .frame_vld(frame_vld), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %h want %h", tag, got, exp);
        end
    endtask

    function automatic int lookup(input logic [6:0] p);
`ifdef SEG7_SCAN_DEC_ONLY_EN
        for (int k = 0; k < 10; k++) if (tbl[k] == p) return k;
`else
        for (int k = 0; k < 16; k++) if (tbl[k] == p) return k;
`endif
        return -1;
    endfunction

    task automatic model_reset();
        m_prev = '0; m_run = 1;
        m_sh = '0; m_hex = '0; m_shok = '0; m_ok = '0; m_seen = '0;
        m_fv = 1'b0; m_err = 1'b0;
    endtask

    // A value sampled for exactly S consecutive edges is captured on the following edge.
    task automatic model_edge(input logic [10:0] cur);
        logic [3:0] a;
        int d;
        m_fv = 1'b0; m_err = 1'b0;
        if (m_seen == 4'hF) begin
            m_hex = m_sh; m_ok = m_shok; m_fv = 1'b1; m_seen = '0;
        end
        if (m_run == S) begin
            a = m_prev[10:7];
            if (a != 0) begin
                if ($countones(a) != 1) m_err = 1'b1;
                else for (int i = 0; i < 4; i++) if (a[i]) begin
                    d = lookup(m_prev[6:0]);
                    m_sh[4*i +: 4] = (d >= 0) ? 4'(d) : 4'd0;
                    m_shok[i] = (d >= 0);
                    m_err = (d < 0);
                    m_seen[i] = 1'b1;
                end
            end
        end
        m_run = (cur == m_prev) ? (m_run > S ? m_run : m_run + 1) : 1;
        m_prev = cur;
    endtask

    task automatic cyc(input logic [3:0] a, input logic [6:0] s, input int n);
        repeat (n) begin
            an = a; seg = s;
            @(posedge clk);
            model_edge({a, s});
            #1;
            fv_cnt += int'(frame_vld);
            err_cnt += int'(err);
            check("cycle", {10'd0, hex_out, digit_ok, frame_vld, err}, {10'd0, m_hex, m_ok, m_fv, m_err});
        end
    endtask

    task automatic scan(input logic [6:0] p0, p1, p2, p3, input int n);
        fv_cnt = 0; err_cnt = 0;
        cyc(4'b0001, p0, n);
        cyc(4'b0010, p1, n);
        cyc(4'b0100, p2, n);
        cyc(4'b1000, p3, n);
        cyc(4'b0000, 7'h7F, 4);
    endtask

    initial begin
        logic [3:0] ra;
        logic [6:0] rs;
        model_reset();
        #12 rst_n = 1'b1;
        check("reset_out", {10'd0, hex_out, digit_ok, frame_vld, err}, 32'd0);

        scan(tbl[1], tbl[2], tbl[3], tbl[4], 8);
        check("scan_fv", fv_cnt, 1);
        check("scan_err", err_cnt, 0);
        check("scan_hex", hex_out, 16'h4321);
        check("scan_ok", digit_ok, 4'hF);

        scan(tbl[1], tbl[2], 7'h7F, tbl[4], 8);
        check("blank_err", err_cnt, 1);
        check("blank_ok", digit_ok, 4'b1011);
        check("blank_hex", hex_out, 16'h4021);

        fv_cnt = 0; err_cnt = 0;
        cyc(4'b0001, tbl[5], 3);
        cyc(4'b0010, tbl[2], 8);
        cyc(4'b0100, tbl[3], 8);
        cyc(4'b1000, tbl[4], 8);
        cyc(4'b0000, 7'h7F, 6);
        check("glitch_nofv", fv_cnt, 0);
        cyc(4'b0001, tbl[6], 4);
        cyc(4'b0000, 7'h7F, 6);
        check("glitch_fv", fv_cnt, 1);
        check("glitch_hex", hex_out, 16'h4326);

        fv_cnt = 0; err_cnt = 0;
        cyc(4'b0101, tbl[7], 10);
        check("multi_err", err_cnt, 1);
        fv_cnt = 0; err_cnt = 0;
        cyc(4'b0000, 7'h7F, 20);
        check("idle_err", err_cnt, 0);
        check("idle_fv", fv_cnt, 0);

        scan(tbl[10], tbl[1], tbl[2], tbl[3], 8);
`ifdef SEG7_SCAN_DEC_ONLY_EN
        check("hexA_err", err_cnt, 1);
        check("hexA_ok", digit_ok, 4'b1110);
        check("hexA_hex", hex_out, 16'h3210);
`else
        check("hexA_err", err_cnt, 0);
        check("hexA_ok", digit_ok, 4'hF);
        check("hexA_hex", hex_out, 16'h321A);
`endif

        fv_cnt = 0; err_cnt = 0;
        cyc(4'b0001, tbl[1], 8);
        cyc(4'b0010, tbl[1], 8);
        cyc(4'b0100, tbl[1], 8);
        #2 rst_n = 1'b0;
        #1 check("rst_mid", {10'd0, hex_out, digit_ok, frame_vld, err}, 32'd0);
        model_reset();
        an = '0; seg = '0;
        repeat (2) @(posedge clk);
        #1 check("rst_hold", {10'd0, hex_out, digit_ok, frame_vld, err}, 32'd0);
        @(negedge clk) rst_n = 1'b1;
        scan(tbl[9], tbl[0], tbl[15], tbl[12], 8);
        check("post_rst_fv", fv_cnt, 1);
`ifdef SEG7_SCAN_DEC_ONLY_EN
        check("post_rst_hex", hex_out, 16'h0009);
        check("post_rst_ok", digit_ok, 4'b0011);
`else
        check("post_rst_hex", hex_out, 16'hCF09);
        check("post_rst_ok", digit_ok, 4'hF);
`endif

        for (int n = 0; n < 300; n++) begin
            int r;
            r = int'($urandom_range(0, 9));
            ra = (r < 7) ? 4'(1 << $urandom_range(0, 3)) : (r < 8) ? 4'd0 : 4'($urandom);
            rs = ($urandom_range(0, 5) == 0) ? 7'($urandom) : tbl[$urandom_range(0, 15)];
            cyc(ra, rs, int'($urandom_range(1, 9)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
